// File: rtl/frac_reduce_pkg.sv
// Shared types and sizing helpers for the frac_reduce block (state encoding, iteration counter width).
package frac_reduce_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIVA = 2'd1,
      DIVB = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int W_DEFAULT = 8;
   localparam int CNT_W     = $clog2(W_DEFAULT + 1);

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first (W >= 2).
// The load cycle already resolves the first quotient bit, so W edges in total yield the result.
module div_seq
   import frac_reduce_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic [W-1:0] quotient,
   output logic [W:0]   remainder
);

   localparam int CW = cnt_width(W);

   logic [W:0]    rem_q;
   logic [W-1:0]  quo_q;
   logic [W-1:0]  dvs_q;
   logic [CW-1:0] cnt_q;

   logic [W-1:0]  src_rem;
   logic [W-1:0]  src_q;
   logic [W-1:0]  src_dvs;
   logic [W:0]    sh;
   logic [W:0]    diff;
   logic [W:0]    rem_d;
   logic [W-1:0]  quo_d;
   logic          ge;

   // Quotient register doubles as the dividend shifter: its MSB feeds the remainder.
   always_comb begin
      src_rem = load ? '0 : rem_q[W-1:0];
      src_q   = load ? dividend : quo_q;
      src_dvs = load ? divisor : dvs_q;
      sh      = {src_rem, src_q[W-1]};
      diff    = sh - {1'b0, src_dvs};
      ge      = (sh >= {1'b0, src_dvs});
      rem_d   = ge ? diff : sh;
      quo_d   = {src_q[W-2:0], ge};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else if (load) begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= divisor;
         cnt_q <= CW'(W - 1);
      end else if (busy) begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign busy      = (cnt_q != '0);
   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/frac_reduce.sv
// Reduces A/B to lowest terms by dividing both by the upstream GCD G, start/done handshake.
// Optional FRAC_REDUCE_CHECK_EN: flags err when either division leaves a nonzero remainder.
module frac_reduce
   import frac_reduce_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic [W-1:0] G,
   output logic         done,
   output logic [W-1:0] N,
   output logic [W-1:0] D,
   output logic         err
);

`ifdef FRAC_REDUCE_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   state_e        st_q, st_d;
   logic [W-1:0]  b_q, g_q, n_q, d_q;
   logic          err_q, rem_bad_q;

   logic          load;
   logic [W-1:0]  dividend, divisor;
   logic          busy;
   logic [W-1:0]  quo;
   logic [W:0]    rem;

   div_seq #(.W(W)) u_div (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .quotient  (quo),
      .remainder (rem)
   );

   // A/G is loaded straight from the ports on the capture edge; B/G reuses the divider after.
   always_comb begin
      st_d     = st_q;
      load     = 1'b0;
      dividend = A;
      divisor  = G;
      case (st_q)
         IDLE: begin
            if (start) begin
               load = (G != '0);
               st_d = (G == '0) ? DONE : DIVA;
            end
         end
         DIVA: begin
            if (!busy) begin
               load     = 1'b1;
               dividend = b_q;
               divisor  = g_q;
               st_d     = DIVB;
            end
         end
         DIVB: begin
            if (!busy) st_d = DONE;
         end
         DONE: begin
            if (!start) st_d = IDLE;
         end
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q      <= IDLE;
         b_q       <= '0;
         g_q       <= '0;
         n_q       <= '0;
         d_q       <= '0;
         err_q     <= 1'b0;
         rem_bad_q <= 1'b0;
      end else begin
         st_q <= st_d;
         case (st_q)
            IDLE: begin
               if (start) begin
                  b_q       <= B;
                  g_q       <= G;
                  rem_bad_q <= 1'b0;
                  if (G == '0) begin
                     n_q   <= A;
                     d_q   <= B;
                     err_q <= 1'b1;
                  end else begin
                     err_q <= 1'b0;
                  end
               end
            end
            DIVA: begin
               if (!busy) begin
                  n_q       <= quo;
                  rem_bad_q <= CHK_EN && (rem != '0);
               end
            end
            DIVB: begin
               if (!busy) begin
                  d_q   <= quo;
                  err_q <= CHK_EN && (rem_bad_q || (rem != '0));
               end
            end
            default: ;
         endcase
      end
   end

   assign done = (st_q == DONE);
   assign N    = n_q;
   assign D    = d_q;
   assign err  = err_q;

endmodule

// File: tb/tb_frac_reduce.sv
// Scoreboard bench for frac_reduce (W=8): driver queues expected results, negedge monitor checks them.
module tb_frac_reduce;

   localparam int W = 8;

`ifdef FRAC_REDUCE_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] n;
      logic [W-1:0] d;
      logic         err;
      int           lat;
      int           cap;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] A = '0, B = '0, G = '0;
   logic         done;
   logic [W-1:0] N, D;
   logic         err;

   int   nvec = 0;
   int   nmis = 0;
   int   cyc  = 0;
   exp_t sb[$];

   frac_reduce #(.W(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .G     (G),
      .done  (done),
      .N     (N),
      .D     (D),
      .err   (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic exp_t model(input int a, input int b, input int g, input int cap);
      exp_t e;
      e.cap = cap;
      if (g == 0) begin
         e.n = a[W-1:0]; e.d = b[W-1:0]; e.err = 1'b1; e.lat = 1;
      end else begin
         int qn, qd;
         qn = a / g;
         qd = b / g;
         e.n   = qn[W-1:0];
         e.d   = qd[W-1:0];
         e.err = CHK && ((a % g) != 0 || (b % g) != 0);
         e.lat = 2 * W + 1;
      end
      return e;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      nvec++;
      if (got != exp) begin
         nmis++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // Monitor: pops one expectation per rising done; checks outputs stay frozen while done holds.
   logic         prev_done = 1'b0;
   logic [W-1:0] hn, hd;
   logic         he;
   exp_t         me;
   int           mlat;

   always @(negedge clk) begin
      if (!rst) begin
         prev_done = 1'b0;
      end else begin
         if (done && !prev_done) begin
            nvec++;
            if (sb.size() == 0) begin
               nmis++;
               $display("FAIL spurious_done N=%0d D=%0d err=%0d", N, D, err);
            end else begin
               me   = sb.pop_front();
               mlat = cyc - me.cap + 1;
               if (N !== me.n || D !== me.d || err !== me.err || mlat != me.lat) begin
                  nmis++;
                  $display("FAIL result got N=%0d D=%0d err=%0d lat=%0d exp N=%0d D=%0d err=%0d lat=%0d",
                           N, D, err, mlat, me.n, me.d, me.err, me.lat);
               end
            end
            hn = N; hd = D; he = err;
         end else if (done && prev_done) begin
            nvec++;
            if (N !== hn || D !== hd || err !== he) begin
               nmis++;
               $display("FAIL hold_stable got N=%0d D=%0d err=%0d exp N=%0d D=%0d err=%0d",
                        N, D, err, hn, hd, he);
            end
         end
         prev_done = done;
      end
   end

   // Called just after a rising edge; returns just after the edge where done falls.
   task automatic run_op(input int a, input int b, input int g, input int hold, input bit pulse);
      int t;
      A = a[W-1:0]; B = b[W-1:0]; G = g[W-1:0];
      start = 1'b1;
      sb.push_back(model(a, b, g, cyc + 1));
      if (pulse) begin
         @(posedge clk); #1;
         start = 1'b0;
         A = $urandom; B = $urandom; G = $urandom;
      end
      t = 0;
      while (!done && t < 40) begin
         @(posedge clk); #1;
         t++;
      end
      if (!done) begin
         nvec++; nmis++;
         $display("FAIL done_timeout a=%0d b=%0d g=%0d", a, b, g);
         void'(sb.pop_front());
      end
      if (!pulse) begin
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("done_held", done, 1);
         end
      end
      start = 1'b0;
      @(posedge clk); #1;
      chk("done_drop", done, 0);
   endtask

   initial begin
      int a, b, g, k;
      #12;
      chk("rst_done", done, 0);
      chk("rst_N", N, 0);
      chk("rst_D", D, 0);
      chk("rst_err", err, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      run_op(12, 18, 6, 0, 1'b0);
      run_op(0, 0, 0, 0, 1'b0);
      run_op(7, 0, 7, 0, 1'b0);
      run_op(127, 1, 1, 0, 1'b0);

      // Abort five edges into DIVA; no result is expected from this one.
      A = 8'd12; B = 8'd18; G = 8'd6; start = 1'b1;
      repeat (6) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("abort_done", done, 0);
      chk("abort_N", N, 0);
      chk("abort_D", D, 0);
      chk("abort_err", err, 0);
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      run_op(9, 6, 3, 0, 1'b0);

      run_op(12, 18, 6, 10, 1'b0);
      run_op(12, 18, 5, 2, 1'b0);
      run_op(100, 50, 25, 0, 1'b1);
      run_op(0, 0, 0, 3, 1'b1);
      run_op(255, 255, 255, 1, 1'b0);
      run_op(255, 1, 1, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            g = $urandom_range(1, 20);
            k = 255 / g;
            a = g * $urandom_range(0, k);
            b = g * $urandom_range(0, k);
         end else begin
            g = $urandom_range(1, 255);
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
         end
         run_op(a, b, g, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      repeat (3) @(posedge clk);
      #1;
      if (sb.size() != 0) begin
         nvec++; nmis++;
         $display("FAIL drain got=%0d pending exp=0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
